// File: rtl/vga_pkg.sv
// Shared colour constants, mode encodings and bar colour tables for the VGA
// test pattern pipeline.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  // Colours are packed {B,G,R}, 4 bits per channel.
  localparam logic [11:0] RED    = 12'h00F;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] BLUE   = 12'hF00;
  localparam logic [11:0] YELLOW = 12'h0FF;
  localparam logic [11:0] AQUA   = 12'hFF0;
  localparam logic [11:0] VIOLET = 12'hF0F;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] GRAY   = 12'hAAA;

  localparam logic [1:0] MODE_BARS   = 2'd0;
  localparam logic [1:0] MODE_SOLID  = 2'd1;
  localparam logic [1:0] MODE_CHECK  = 2'd2;
  localparam logic [1:0] MODE_SCROLL = 2'd3;

  function automatic logic [11:0] upper_bar(input logic [2:0] idx);
    unique case (idx)
      3'd0: upper_bar = WHITE;
      3'd1: upper_bar = YELLOW;
      3'd2: upper_bar = AQUA;
      3'd3: upper_bar = GREEN;
      3'd4: upper_bar = VIOLET;
      3'd5: upper_bar = RED;
      3'd6: upper_bar = BLUE;
      default: upper_bar = BLACK;
    endcase
  endfunction

  function automatic logic [11:0] lower_bar(input logic [2:0] idx);
    unique case (idx)
      3'd0: lower_bar = BLUE;
      3'd1: lower_bar = BLACK;
      3'd2: lower_bar = VIOLET;
      3'd3: lower_bar = GRAY;
      3'd4: lower_bar = AQUA;
      3'd5: lower_bar = BLACK;
      3'd6: lower_bar = WHITE;
      default: lower_bar = GRAY;
    endcase
  endfunction

endpackage

// File: rtl/bar_index_calc.sv
// Maps a pixel column to a colour-bar index using a comparator chain; the last
// bar absorbs the remainder of H_ACTIVE / NUM_BARS.
module bar_index_calc #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned NUM_BARS = 7
) (
  input  logic [9:0] x,
  output logic [2:0] idx
);

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

  always_comb begin
    idx = 3'd0;
    for (int unsigned i = 1; i < NUM_BARS; i++) begin
      if (32'(x) >= i * BAR_W) idx = 3'(i);
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Registered 12-bit RGB test pattern generator: bars, solid, checkerboard and
// scrolling bars, with frame-synchronous mode latching and debounced blanking.
module test_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned NUM_BARS     = 7,
  parameter int unsigned SPLIT_Y      = 412,
  parameter int unsigned TILE_LOG2    = 5,
  parameter int unsigned FLASH_BIT    = 4,
  parameter int unsigned SCROLL_STEP  = 4,
  parameter int unsigned BLANK_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_start,
  input  logic [1:0]  mode_sel,
  input  logic [11:0] solid_rgb,
  input  logic        blank_req,
  output logic [11:0] rgb_out,
  output logic        blank_active,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned DW = $clog2(BLANK_FRAMES + 1);
  localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
  localparam logic [10:0] STEP11 = 11'(SCROLL_STEP);
  localparam logic [DW-1:0] DEB_MAX = DW'(BLANK_FRAMES);

  logic [11:0]   rgb_q, solid_q, pix;
  logic [1:0]    mode_q;
  logic [7:0]    frame_cnt_q;
  logic [9:0]    scroll_q, scroll_d, xs;
  logic [DW-1:0] deb_q, deb_d;
  logic          blank_q;
  logic [10:0]   xs_sum, sc_sum;
  logic [2:0]    idx_x, idx_xs;
  logic          lower;

  assign xs_sum = {1'b0, x} + {1'b0, scroll_q};
  assign xs = (xs_sum >= H_ACT11) ? 10'(xs_sum - H_ACT11) : 10'(xs_sum);
  assign sc_sum = {1'b0, scroll_q} + STEP11;
  assign scroll_d = (sc_sum >= H_ACT11) ? 10'(sc_sum - H_ACT11) : 10'(sc_sum);
  assign deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
  assign lower = (32'(y) >= SPLIT_Y);

  bar_index_calc #(.H_ACTIVE(H_ACTIVE), .NUM_BARS(NUM_BARS)) u_idx_x (
    .x   (x),
    .idx (idx_x)
  );

  bar_index_calc #(.H_ACTIVE(H_ACTIVE), .NUM_BARS(NUM_BARS)) u_idx_xs (
    .x   (xs),
    .idx (idx_xs)
  );

  always_comb begin
    pix = BLACK;
    if (video_on && (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE) && !blank_q) begin
      unique case (mode_q)
        MODE_BARS:   pix = lower ? lower_bar(idx_x) : upper_bar(idx_x);
        MODE_SOLID:  pix = solid_q;
        MODE_CHECK:  pix = (x[TILE_LOG2] ^ y[TILE_LOG2] ^ frame_cnt_q[FLASH_BIT]) ? WHITE : BLACK;
        MODE_SCROLL: pix = lower ? lower_bar(idx_xs) : upper_bar(idx_xs);
        default:     pix = BLACK;
      endcase
    end
  end

  // The boundary pixel itself is rendered from pre-update state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q       <= BLACK;
      solid_q     <= BLACK;
      mode_q      <= MODE_BARS;
      frame_cnt_q <= '0;
      scroll_q    <= '0;
      deb_q       <= '0;
      blank_q     <= 1'b0;
    end else if (p_tick) begin
      rgb_q <= pix;
      if (frame_start) begin
        mode_q      <= mode_sel;
        solid_q     <= solid_rgb;
        frame_cnt_q <= frame_cnt_q + 8'd1;
        scroll_q    <= scroll_d;
        if (blank_req) begin
          deb_q   <= deb_d;
          blank_q <= (deb_d == DEB_MAX);
        end else begin
          deb_q   <= '0;
          blank_q <= 1'b0;
        end
      end
    end
  end

  assign rgb_out      = rgb_q;
  assign blank_active = blank_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: directed pixels push expected values,
// a monitor pops and compares them when the output is presented.
module tb_test_pattern_gen;

  localparam int K_RGB   = 0;
  localparam int K_FC    = 1;
  localparam int K_BLANK = 2;
  localparam int K_ALL0  = 3;

  typedef struct {
    int          kind;
    logic [20:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        frame_start = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic [11:0] solid_rgb = '0;
  logic        blank_req = 1'b0;
  logic [11:0] rgb_out;
  logic        blank_active;
  logic [7:0]  frame_cnt;

  logic        probe = 1'b0;
  item_t       sb[$];
  item_t       it;
  logic [20:0] act;
  int          n_vec = 0;
  int          n_fail = 0;

  test_pattern_gen dut (
    .clk          (clk),
    .reset        (reset),
    .p_tick       (p_tick),
    .video_on     (video_on),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .mode_sel     (mode_sel),
    .solid_rgb    (solid_rgb),
    .blank_req    (blank_req),
    .rgb_out      (rgb_out),
    .blank_active (blank_active),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are sampled on the falling edge while probe is raised.
  always @(negedge clk) begin
    if (probe) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: output presented with nothing expected");
      end else begin
        it = sb.pop_front();
        case (it.kind)
          K_RGB:   act = {9'd0, rgb_out};
          K_FC:    act = {13'd0, frame_cnt};
          K_BLANK: act = {20'd0, blank_active};
          default: act = {rgb_out, frame_cnt, blank_active};
        endcase
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic expect_now(input int kind, input logic [20:0] exp, input string name);
    item_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py, input logic vo, input logic [11:0] exp,
                     input string name);
    x        = 10'(px);
    y        = 10'(py);
    video_on = vo;
    p_tick   = 1'b1;
    @(posedge clk);
    #1 p_tick = 1'b0;
    expect_now(K_RGB, {9'd0, exp}, name);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      video_on    = 1'b0;
      x           = 10'd700;
      y           = 10'd490;
      frame_start = 1'b1;
      p_tick      = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      p_tick      = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_now(K_ALL0, 21'd0, "reset_state");

    // Mode 0 bars, frame 0
    pix(0, 0, 1'b1, 12'hFFF, "bars_0_0");
    pix(90, 0, 1'b1, 12'hFFF, "bars_90_0");
    pix(91, 0, 1'b1, 12'h0FF, "bars_91_0");
    pix(639, 411, 1'b1, 12'hF00, "bars_639_411");
    pix(273, 412, 1'b1, 12'hAAA, "bars_273_412");
    pix(639, 479, 1'b1, 12'hFFF, "bars_639_479");
    pix(640, 0, 1'b1, 12'h000, "bars_x_oob");
    pix(0, 480, 1'b1, 12'h000, "bars_y_oob");

    // Mode 3 scroll: first frame scroll = 4
    mode_sel = 2'd3;
    pix(0, 0, 1'b1, 12'hFFF, "scroll_before_boundary");
    frames(1);
    pix(87, 0, 1'b1, 12'h0FF, "scroll4_x87");
    pix(86, 0, 1'b1, 12'hFFF, "scroll4_x86");
    pix(635, 0, 1'b1, 12'hF00, "scroll4_x635");
    pix(636, 0, 1'b1, 12'hFFF, "scroll4_x636_wrap");
    frames(159);
    expect_now(K_FC, 21'd160, "fc_160");
    pix(0, 0, 1'b1, 12'hFFF, "scroll0_x0");
    pix(87, 0, 1'b1, 12'hFFF, "scroll0_x87");

    // Mode 1 solid, requested mid-frame
    mode_sel  = 2'd1;
    solid_rgb = 12'h5A3;
    pix(91, 0, 1'b1, 12'h0FF, "solid_mid_frame_old");
    frames(1);
    pix(0, 0, 1'b1, 12'h5A3, "solid_0_0");
    pix(639, 479, 1'b1, 12'h5A3, "solid_639_479");
    pix(300, 200, 1'b0, 12'h000, "solid_video_off");
    solid_rgb = 12'h123;
    pix(300, 200, 1'b1, 12'h5A3, "solid_change_held");

    // Mode 2 checkerboard: frame 162 has flash bit 0, frame 176 has it set
    mode_sel = 2'd2;
    frames(1);
    pix(0, 0, 1'b1, 12'h000, "check_0_0_ph0");
    pix(32, 0, 1'b1, 12'hFFF, "check_32_0_ph0");
    pix(32, 32, 1'b1, 12'h000, "check_32_32_ph0");
    frames(14);
    expect_now(K_FC, 21'd176, "fc_176");
    pix(0, 0, 1'b1, 12'hFFF, "check_0_0_ph1");
    pix(32, 0, 1'b1, 12'h000, "check_32_0_ph1");

    // Frame counter wrap 255 -> 0
    mode_sel = 2'd0;
    frames(80);
    expect_now(K_FC, 21'd0, "fc_wrap");

    // Blank debounce
    blank_req = 1'b1;
    frames(1);
    expect_now(K_BLANK, 21'd0, "blank_b1");
    pix(0, 0, 1'b1, 12'hFFF, "blank_b1_pix");
    frames(1);
    expect_now(K_BLANK, 21'd0, "blank_b2");
    frames(1);
    expect_now(K_BLANK, 21'd1, "blank_b3");
    pix(0, 0, 1'b1, 12'h000, "blanked_0_0");
    pix(91, 0, 1'b1, 12'h000, "blanked_91_0");
    frames(1);
    blank_req = 1'b0;
    pix(91, 0, 1'b1, 12'h000, "blank_drop_mid_frame");
    frames(1);
    expect_now(K_BLANK, 21'd0, "blank_released");
    pix(91, 0, 1'b1, 12'h0FF, "unblanked_91_0");
    blank_req = 1'b1;
    frames(2);
    blank_req = 1'b0;
    frames(1);
    blank_req = 1'b1;
    frames(2);
    expect_now(K_BLANK, 21'd0, "glitch_count_reset");
    frames(1);
    expect_now(K_BLANK, 21'd1, "glitch_then_b3");
    blank_req = 1'b0;
    frames(1);

    // Async reset mid-line with p_tick low
    mode_sel  = 2'd1;
    solid_rgb = 12'h5A3;
    frames(1);
    expect_now(K_FC, 21'd13, "fc_13");
    pix(100, 100, 1'b1, 12'h5A3, "pre_reset_solid");
    reset = 1'b1;
    #1;
    begin
      item_t e;
      e.kind = K_ALL0;
      e.exp  = 21'd0;
      e.name = "async_reset";
      sb.push_back(e);
    end
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    pix(91, 0, 1'b1, 12'h0FF, "post_reset_mode0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
Parametrised, registered successor to the combinational colour-bar generator. It produces 12-bit RGB for the VGA pixel pipeline. It supports four selectable patterns, frame-synchronous mode changes, a per-frame scroll/flash animation, and a debounced frame-aligned blanking request used by the screen-off controller. It sits between the VGA sync counter (which supplies x, y, video_on, p_tick and frame_start) and the RGB pins.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
NUM_BARS, 7, colour-bar count, 1..8
SPLIT_Y, 412, first line of the lower bar band
TILE_LOG2, 5, checkerboard tile size = 2^TILE_LOG2 pixels
FLASH_BIT, 4, frame_cnt bit that selects checkerboard phase
SCROLL_STEP, 4, pixels the scrolling bars advance per frame
BLANK_FRAMES, 3, consecutive frame boundaries blank_req must be high before blanking

Ports:
clk  in  1  system/pixel-domain clock
reset  in  1  asynchronous, active-high reset
p_tick  in  1  pixel enable; all state advances only when high
video_on  in  1  active-video flag from the sync counter
x  in  10  pixel column
y  in  10  pixel row
frame_start  in  1  one-p_tick pulse per frame, issued during vertical blanking
mode_sel  in  2  0 = bars, 1 = solid, 2 = checkerboard, 3 = scrolling bars
solid_rgb  in  12  colour for mode 1
blank_req  in  1  level request to blank the screen
rgb_out  out  12  registered pixel colour
blank_active  out  1  high while the output is forced black by a blank request
frame_cnt  out  8  free-running frame counter

Behaviour:
- Reset (async, active-high) clears everything to 0: rgb_out = 000, blank_active = 0, frame_cnt = 0, scroll = 0, debounce counter = 0, active mode = 0, active solid colour = 000.
- Latency: rgb_out is registered on clk when p_tick = 1, one p_tick after x/y/video_on. When p_tick = 0 all registers hold.
- Colour encoding is {B,G,R}, 4 bits each: RED = 00F, GREEN = 0F0, BLUE = F00, YELLOW = 0FF, AQUA = FF0, VIOLET = F0F, WHITE = FFF, BLACK = 000, GRAY = AAA.
- Frame boundary means frame_start & p_tick. At each boundary:
  - mode_sel and solid_rgb are latched into the active registers. Mid-frame changes are ignored until the next boundary.
  - frame_cnt increments and wraps from 255 to 0.
  - scroll becomes (scroll + SCROLL_STEP) mod H_ACTIVE. scroll is used only in mode 3 but advances in all modes.
  - Blank debounce: if blank_req = 1, the counter increments (saturating at BLANK_FRAMES). blank_active goes to 1 when the counter reaches BLANK_FRAMES. If blank_req = 0, the counter is cleared and blank_active = 0.
- The boundary pixel itself renders with pre-update settings. frame_start asserted while video_on = 1 is still honoured but is a protocol violation.
- Output priority, highest first:
  1. video_on = 0 → BLACK.
  2. x ≥ H_ACTIVE or y ≥ V_ACTIVE → BLACK.
  3. blank_active → BLACK.
  4. Otherwise, the pattern selected by the active mode.
- Bar geometry: BAR_W = H_ACTIVE / NUM_BARS (integer division). bar index = min(x / BAR_W, NUM_BARS-1), implemented with a comparator chain (no divider). The last bar absorbs the remainder; at defaults the boundaries are 91, 182, …, 546 and the last bar is 94 pixels wide.
- Mode 0 (bars):
  - y < SPLIT_Y uses the upper table, indexed by bar index: WHITE, YELLOW, AQUA, GREEN, VIOLET, RED, BLUE, BLACK.
  - Otherwise the lower table: BLUE, BLACK, VIOLET, GRAY, AQUA, BLACK, WHITE, GRAY.
- Mode 1 (solid): active solid colour.
- Mode 2 (checkerboard): WHITE if (x[9:TILE_LOG2] ^ y[9:TILE_LOG2] ^ frame_cnt[FLASH_BIT]) LSB is 1, else BLACK.
- Mode 3 (scrolling bars): as mode 0, but using xs = x + scroll, with H_ACTIVE subtracted if the sum is ≥ H_ACTIVE (11-bit sum, wraps cleanly).
- Reset asserted mid-frame forces all outputs to 0 immediately. After release, output resumes in mode 0, unblanked, at the next p_tick.

Decomposition:
- Package vga_pkg holds:
  - colour localparams (RED … GRAY) and the mode encodings MODE_BARS, MODE_SOLID, MODE_CHECK, MODE_SCROLL;
  - the 8-entry upper and lower bar tables as functions;
  - the default H_ACTIVE/V_ACTIVE.
- One sub-module, bar_index_calc: combinational, parametrised by H_ACTIVE and NUM_BARS, maps a 10-bit x to a 3-bit bar index. It is instantiated twice, for x and for xs.

Test Plan:
- Reset, then mode 0 with video_on = 1, sampled one p_tick later:
  - (0,0) → FFF, (90,0) → FFF, (91,0) → 0FF, (639,411) → F00;
  - (273,412) → AAA, (639,479) → FFF.
- Mode 1 with solid_rgb = 5A3, changed mid-frame: output keeps the old pattern until after the next frame_start; the following frame shows 5A3 everywhere. With video_on = 0 the output is 000.
- Mode 2: pixel (0,0) is 000 and pixel (32,0) is FFF while frame_cnt = 0. After 16 frame boundaries, frame_cnt = 16 and (0,0) → FFF.
- Mode 3: after 1 frame boundary scroll = 4, so x = 87 → 0FF (xs = 91). After 160 boundaries scroll wraps to 0, and x = 0 → FFF again.
- blank_req held high:
  - blank_active stays 0 after boundaries 1–2 and rises at boundary 3, after which every pixel is 000;
  - dropping blank_req restores the image at the next boundary;
  - a high-low-high glitch resets the count.
- Async reset pulse mid-line with p_tick = 0: rgb_out, frame_cnt and blank_active are all 0 before the next clk edge.
